// File: rtl/barrel_shift_sequencer_if.sv
// Command, shifter and result bus of barrel_shift_sequencer.
// master = sequencer side, slave = environment (producer, shifter, consumer).
interface barrel_shift_sequencer_if #(parameter int DEPTH = 4);
   logic                     flush;
   logic                     in_valid, in_ready;
   logic                     in_select, in_direction;
   logic [1:0]               in_shift_value;
   logic [3:0]               in_din;
   logic                     bs_select, bs_direction;
   logic [1:0]               bs_shift_value;
   logic [3:0]               bs_din, bs_dout;
   logic                     out_valid, out_ready;
   logic [3:0]               out_data, out_din;
   logic [$clog2(DEPTH):0]   level;
`ifdef BARREL_SEQ_COUNT_EN
   logic [15:0]              op_count;
`endif

   modport master (
      input  flush, in_valid, in_select, in_direction, in_shift_value, in_din,
             bs_dout, out_ready,
      output in_ready, bs_select, bs_direction, bs_shift_value, bs_din,
             out_valid, out_data, out_din, level
`ifdef BARREL_SEQ_COUNT_EN
      , output op_count
`endif
   );

   modport slave (
      output flush, in_valid, in_select, in_direction, in_shift_value, in_din,
             bs_dout, out_ready,
      input  in_ready, bs_select, bs_direction, bs_shift_value, bs_din,
             out_valid, out_data, out_din, level
`ifdef BARREL_SEQ_COUNT_EN
      , input op_count
`endif
   );
endinterface

// File: rtl/barrel_shift_sequencer.sv
// Command FIFO + registered result slot wrapped around a combinational barrel shifter.
// Optional BARREL_SEQ_COUNT_EN adds a 16-bit result-handshake counter (op_count).
module barrel_shift_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   barrel_shift_sequencer_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic       sel;
      logic       dir;
      logic [1:0] amt;
      logic [3:0] din;
   } cmd_t;

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW:0]   wptr, rptr;
   logic          full, empty, push, pop, hs;
   slot_t         slot;
   logic [3:0]    out_data_q, out_din_q;

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign hs    = (slot == SLOT_FULL) && bus.out_ready;
   assign push  = bus.in_valid && bus.in_ready;
   // in_ready already excludes flush; pop must be masked explicitly
   assign pop   = !empty && ((slot == SLOT_EMPTY) || bus.out_ready) && !bus.flush;
   assign head  = mem[rptr[AW-1:0]];

   assign bus.in_ready  = !full && !bus.flush;
   assign bus.level     = wptr - rptr;
   assign bus.out_valid = (slot == SLOT_FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_din   = out_din_q;

   always_comb begin
      bus.bs_select      = 1'b0;
      bus.bs_direction   = 1'b0;
      bus.bs_shift_value = 2'd0;
      bus.bs_din         = 4'd0;
      if (!empty) begin
         bus.bs_select      = head.sel;
         bus.bs_direction   = head.dir;
         bus.bs_shift_value = head.amt;
         bus.bs_din         = head.din;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[AW-1:0]] <= '{sel: bus.in_select, dir: bus.in_direction,
                                amt: bus.in_shift_value, din: bus.in_din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bus.flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Result slot: a pop always refills it, so drain only happens with the FIFO empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot       <= SLOT_EMPTY;
         out_data_q <= 4'd0;
         out_din_q  <= 4'd0;
      end else if (bus.flush) begin
         slot <= SLOT_EMPTY;
      end else begin
         case (slot)
            SLOT_EMPTY: if (pop) begin
               slot       <= SLOT_FULL;
               out_data_q <= bus.bs_dout;
               out_din_q  <= head.din;
            end
            SLOT_FULL: if (pop) begin
               out_data_q <= bus.bs_dout;
               out_din_q  <= head.din;
            end else if (hs) begin
               slot <= SLOT_EMPTY;
            end
            default: slot <= SLOT_EMPTY;
         endcase
      end
   end

`ifdef BARREL_SEQ_COUNT_EN
   logic [15:0] cnt;
   assign bus.op_count = cnt;

   // Not cleared by flush: counts every result handshake since reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  cnt <= 16'd0;
      else if (hs) cnt <= cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Randomized + directed bench for barrel_shift_sequencer against a queue-based model.
// Honours BARREL_SEQ_COUNT_EN when defined.
module tb_barrel_shift_sequencer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       sel;
      logic       dir;
      logic [1:0] amt;
      logic [3:0] din;
   } tcmd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   barrel_shift_sequencer_if #(.DEPTH(DEPTH)) bif ();

   barrel_shift_sequencer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   // Reference barrel shifter: logical zero-fill shift, plain rotate
   function automatic logic [3:0] shf(input logic sel, input logic dir,
                                      input logic [1:0] amt, input logic [3:0] d);
      int x, a, r;
      x = int'(d);
      a = int'(amt);
      if (sel) r = dir ? ((x << a) | (x >> (4 - a))) : ((x >> a) | (x << (4 - a)));
      else     r = dir ? (x << a) : (x >> a);
      return 4'(r & 15);
   endfunction

   assign bif.bs_dout = shf(bif.bs_select, bif.bs_direction, bif.bs_shift_value, bif.bs_din);

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   tcmd_t      q[$];
   logic       mvalid = 1'b0;
   logic [3:0] mdata  = 4'd0;
   logic [3:0] mdin   = 4'd0;
   int         mcnt   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mvalid = 1'b0;
         mdata  = 4'd0;
         mdin   = 4'd0;
         mcnt   = 0;
      end else begin
         logic  can_push, do_pop, hs;
         tcmd_t c, h;
         hs       = mvalid && bif.out_ready;
         can_push = bif.in_valid && (q.size() < DEPTH) && !bif.flush;
         do_pop   = (q.size() > 0) && (!mvalid || bif.out_ready) && !bif.flush;
         c = '{sel: bif.in_select, dir: bif.in_direction,
               amt: bif.in_shift_value, din: bif.in_din};
         if (hs) mcnt = (mcnt + 1) % 65536;
         if (bif.flush) begin
            q.delete();
            mvalid = 1'b0;
         end else begin
            if (do_pop) begin
               h      = q.pop_front();
               mdata  = shf(h.sel, h.dir, h.amt, h.din);
               mdin   = h.din;
               mvalid = 1'b1;
            end else if (hs) begin
               mvalid = 1'b0;
            end
            if (can_push) q.push_back(c);
         end
      end
   end

   // ---------------- per-cycle comparator ----------------
   always @(negedge clk) begin
      tcmd_t hd;
      hd = (q.size() > 0) ? q[0] : tcmd_t'(8'd0);
      chk("in_ready",  16'(bif.in_ready),  16'((q.size() < DEPTH) && !bif.flush));
      chk("out_valid", 16'(bif.out_valid), 16'(mvalid));
      chk("out_data",  16'(bif.out_data),  16'(mdata));
      chk("out_din",   16'(bif.out_din),   16'(mdin));
      chk("level",     16'(bif.level),     16'(q.size()));
      chk("bs_head",   16'({bif.bs_select, bif.bs_direction, bif.bs_shift_value, bif.bs_din}),
                       16'(hd));
`ifdef BARREL_SEQ_COUNT_EN
      chk("op_count",  bif.op_count,       16'(mcnt));
`endif
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sel, input logic dir,
                        input logic [1:0] amt, input logic [3:0] d);
      bif.in_valid       = v;
      bif.in_select      = sel;
      bif.in_direction   = dir;
      bif.in_shift_value = amt;
      bif.in_din         = d;
   endtask

   task automatic idle_until_empty();
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
   endtask

   initial begin
      logic [3:0] exp2 [4];
      bif.flush = 1'b0;
      bif.out_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      #1 rst_n = 1'b0;
      step();
      step();
      chk("rst_in_ready",  16'(bif.in_ready),  16'd1);
      chk("rst_out_valid", 16'(bif.out_valid), 16'd0);
      chk("rst_level",     16'(bif.level),     16'd0);
      chk("rst_out_data",  16'(bif.out_data),  16'd0);
      rst_n = 1'b1;
      step();

      // Single rotate-left-by-1 of 4'b1001
      bif.out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 2'd1, 4'b1001);
      step();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      chk("t1_bs_din", 16'(bif.bs_din), 16'h9);
      step();
      chk("t1_valid", 16'(bif.out_valid), 16'd1);
      chk("t1_data",  16'(bif.out_data),  16'b0011);
      chk("t1_din",   16'(bif.out_din),   16'b1001);
      chk("t1_level", 16'(bif.level),     16'd0);
      idle_until_empty();

      // Back-to-back rotate-right-by-2: 1,2,4,8 -> 4,8,1,2
      exp2 = '{4'd4, 4'd8, 4'd1, 4'd2};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 2'd2, 4'(1 << i));
         step();
         if (i > 0) chk("t2_stream", 16'(bif.out_data), 16'(exp2[i-1]));
      end
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      step();
      chk("t2_stream_last", 16'(bif.out_data), 16'(exp2[3]));
      chk("t2_valid",       16'(bif.out_valid), 16'd1);
      idle_until_empty();

      // Back-pressure: 6 offered, 5 accepted
      bif.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b1, 2'd1, 4'(i + 3));
         step();
      end
      chk("t3_in_ready", 16'(bif.in_ready), 16'd0);
      chk("t3_level",    16'(bif.level),    16'd4);
      chk("t3_held_din", 16'(bif.out_din),  16'd3);
      chk("t3_held_dat", 16'(bif.out_data), 16'd6);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      idle_until_empty();

      // Simultaneous push/pop at level 2
      bif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 2'd0, 4'(i + 10));
         step();
      end
      chk("t4_level_before", 16'(bif.level), 16'd2);
      bif.out_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd13);
      step();
      chk("t4_level_after", 16'(bif.level),  16'd2);
      chk("t4_order",       16'(bif.out_din), 16'd11);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      idle_until_empty();

      // Flush with level 3 + slot full + in_valid
      bif.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b1, 2'd3, 4'(i + 1));
         step();
      end
      chk("t5_level_pre", 16'(bif.level), 16'd3);
      bif.flush = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'd1, 4'hF);
      step();
      bif.flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
      chk("t5_level",     16'(bif.level),     16'd0);
      chk("t5_out_valid", 16'(bif.out_valid), 16'd0);
      step();
      chk("t5_dropped",   16'(bif.level),     16'd0);

      // Random traffic with an asynchronous reset in the middle
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               2'($urandom), 4'($urandom));
         bif.out_ready = 1'($urandom_range(0, 2) != 0);
         bif.flush     = ($urandom_range(0, 39) == 0);
         if (i == 300) begin
            bif.flush = 1'b0;
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("ar_out_valid", 16'(bif.out_valid), 16'd0);
            chk("ar_level",     16'(bif.level),     16'd0);
            chk("ar_out_data",  16'(bif.out_data),  16'd0);
            chk("ar_out_din",   16'(bif.out_din),   16'd0);
            chk("ar_in_ready",  16'(bif.in_ready),  16'd1);
            chk("ar_bs",        16'({bif.bs_select, bif.bs_direction,
                                     bif.bs_shift_value, bif.bs_din}), 16'd0);
`ifdef BARREL_SEQ_COUNT_EN
            chk("ar_op_count",  bif.op_count, 16'd0);
`endif
            step();
            rst_n = 1'b1;
         end
         step();
      end
      bif.flush = 1'b0;
      idle_until_empty();

`ifdef BARREL_SEQ_COUNT_EN
      begin
         int n, guard;
         rst_n = 1'b0;
         step();
         chk("cnt_reset", bif.op_count, 16'd0);
         rst_n = 1'b1;
         step();
         n = 0;
         guard = 0;
         bif.out_ready = 1'b1;
         while (n < 65536 && guard < 70000) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
            if (bif.out_valid && bif.out_ready) n++;
            step();
            guard++;
         end
         bif.out_ready = 1'b0;
         drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
         chk("cnt_budget", 16'(n == 65536), 16'd1);
         chk("cnt_wrap",   bif.op_count, 16'd0);
         idle_until_empty();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/barrel_shift_sequencer.md
# barrel_shift_sequencer

Sequencing stage that sits directly upstream of `barrel_shifter` and also captures its result. It accepts shift/rotate commands over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the combinational barrel shifter and registers the returned `dout` into an output slot with its own valid/ready handshake. This gives the combinational shifter a back-pressure-aware, one-command-per-cycle pipeline wrapper.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous clear of FIFO and output slot
- in_valid  input  1  command offered
- in_ready  output  1  command can be accepted
- in_select  input  1  0 = shift, 1 = rotate
- in_direction  input  1  0 = right, 1 = left
- in_shift_value  input  2  shift amount, 0..3
- in_din  input  4  operand
- bs_select, bs_direction  output  1 each  to barrel_shifter
- bs_shift_value  output  2  to barrel_shifter
- bs_din  output  4  to barrel_shifter
- bs_dout  input  4  result from barrel_shifter (combinational)
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- out_data  output  4  registered bs_dout
- out_din  output  4  operand that produced out_data (echo for checking)
- level  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- The FIFO stores {select, direction, shift_value, din}, 8 bits per entry. It uses write and read pointers of $clog2(DEPTH)+1 bits, with the MSB acting as the wrap bit.
  - full = pointers equal except for the MSB.
  - empty = pointers fully equal.
- `in_ready` = !full && !flush.
- Push occurs when in_valid && in_ready.
- bs_* always reflect the FIFO head. They are driven to 0 when the FIFO is empty.
- The output slot is a 2-state FSM:
  - SLOT_EMPTY: out_valid = 0.
  - SLOT_FULL: out_valid = 1.
- Pop / load: when the FIFO is non-empty and (slot is SLOT_EMPTY, or out_valid && out_ready), the stage does all of the following on the same edge:
  - pops the head;
  - loads out_data ← bs_dout and out_din ← head din;
  - sets the slot to SLOT_FULL.
- Drain: when out_valid && out_ready and the FIFO is empty, the slot goes to SLOT_EMPTY and out_data/out_din hold their values.
- Simultaneous push and pop are allowed in every state:
  - on full, a pop frees a slot only for the following cycle, because in_ready does not depend on out_ready;
  - on empty, a pushed entry becomes the head one cycle later; there is no bypass.
- `level` changes as follows: +1 on push only, −1 on pop only, unchanged on both or neither.
- Flush: on the next edge, pointers return to 0, level goes to 0, and the slot goes to SLOT_EMPTY. A push or pop requested in the same cycle is discarded.
- The stage never modifies data. Zero-fill or sign semantics come entirely from barrel_shifter.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_din = 0, level = 0, bs_* = 0, and the counter (when compiled in) = 0.
- Latency: a command accepted at edge k appears on bs_* after k. Its result is registered with out_valid = 1 after edge k+1, provided the slot is free. Minimum latency is 2 cycles from in_valid to out_valid.
- Throughput: one command per cycle when out_ready is held high.
- Stall behaviour: while out_valid && !out_ready, out_data, out_din and out_valid hold stable and the FIFO keeps accepting until full.
- Reset mid-operation: state clears asynchronously, all in-flight commands are lost, and outputs take their reset values immediately.

## Configuration
- `BARREL_SEQ_COUNT_EN` defined:
  - adds output `op_count`, 16 bits, which increments on every result handshake (out_valid && out_ready);
  - the counter wraps from 16'hFFFF to 0;
  - the counter is cleared by rst_n but is not cleared by flush.
- `BARREL_SEQ_COUNT_EN` undefined: the port and counter are absent, and the rest of the behaviour is identical.

## Test plan
- Reset, then one command with rotate left by 1 and din = 4'b1001, out_ready = 1 → after 2 cycles, out_valid = 1, out_data = 4'b0011, out_din = 4'b1001; level returns to 0.
- Four back-to-back rotate-right-by-2 commands with din = 1,2,4,8 and out_ready = 1 → results 4,8,1,2 on consecutive cycles, no bubbles.
- out_ready = 0 while pushing 6 commands (DEPTH = 4) → in_ready drops when level = 4 with one result held; out_data stays stable. Releasing out_ready drains all 5 accepted commands in order.
- Push and pop in the same cycle at level = 2 → level stays 2; FIFO order is preserved.
- flush asserted with level = 3 and out_valid = 1, plus in_valid in the same cycle → next cycle level = 0, out_valid = 0, and the command is dropped.
- rst_n pulled low mid-stream → outputs reset without waiting for a clock edge. With BARREL_SEQ_COUNT_EN defined, op_count returns to 0, then counts 65536 handshakes back to 0.
